// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake/data bundle for the shift-and-add multiplier controller.
interface shift_add_mult_ctrl_if #(
  parameter int unsigned N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned multiplier: one N-bit ripple-carry adder reused for N
// add/shift steps, result {A,Q} registered with a one-cycle done strobe.
module shift_add_mult_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   m_reg;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   q_reg;
  logic [CW-1:0]  count;
  logic [2*N-1:0] product_reg;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic [N:0]     carry;
  logic           cout;
  logic [2*N-1:0] shifted;

  // Single ripple-carry adder, carry-in tied low.
  always_comb begin
    addend = q_reg[0] ? m_reg : '0;
    carry  = '0;
    sum    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i]       = a_reg[i] ^ addend[i] ^ carry[i];
      carry[i+1]   = (a_reg[i] & addend[i]) | (carry[i] & (a_reg[i] ^ addend[i]));
    end
    cout = carry[N];
  end

  // The carry shifts straight into A[N-1], so the carry flop would always
  // reload 0 and is folded away.
  assign shifted = {cout, sum, q_reg[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      count       <= '0;
      product_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_reg <= bus.a;
            q_reg <= bus.b;
            a_reg <= '0;
            count <= CW'(N);
          end
        end
        RUN: begin
          {a_reg, q_reg} <= shifted;
          count          <= count - 1'b1;
          if (count == CW'(1)) product_reg <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl (N=8).
module tb_shift_add_mult_ctrl;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst;

  shift_add_mult_ctrl_if #(.N(N)) bus ();

  shift_add_mult_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Completion monitor: every done pops one expected product.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else                  check("product", 32'(bus.product), sb_q.pop_front());
    end
  end

  // Called at a negedge; drives start for exactly one rising edge.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    sb_q.push_back(32'(x) * 32'(y));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom_range(255, 0);
    bus.b     = $urandom_range(255, 0);
  endtask

  // Entered at the negedge after the start edge; leaves at the first IDLE negedge.
  task automatic expect_run(input int hold);
    for (int i = 0; i < int'(N); i++) begin
      check("busy_run", 32'(bus.busy), 32'd1);
      check("done_run", 32'(bus.done), 32'd0);
      if (hold >= 0) check("product_hold", 32'(bus.product), 32'(hold));
      @(negedge clk);
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("done_drop", 32'(bus.done), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op(8'd123, 8'd123); expect_run(0);
    start_op(8'd255, 8'd255); expect_run(15129);
    start_op(8'd0, 8'd200);   expect_run(65025);
    start_op(8'd200, 8'd0);   expect_run(0);

    // start held high through RUN and DONE; operands change mid-operation
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd13;
    sb_q.push_back(32'd39);
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) begin
      check("busy_hold", 32'(bus.busy), 32'd1);
      if (i == 3) begin bus.a = 8'd7; bus.b = 8'd7; end
      @(negedge clk);
    end
    check("done_hold", 32'(bus.done), 32'd1);
    sb_q.push_back(32'd49);
    @(negedge clk);
    check("idle_hold_busy", 32'(bus.busy), 32'd0);
    check("idle_hold_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    expect_run(39);

    // reset in the middle of a run aborts it
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd100;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 32'd0);
    end
    start_op(8'd5, 8'd6); expect_run(0);

    // back-to-back: second start in the first IDLE cycle
    start_op(8'd17, 8'd15);  expect_run(30);
    start_op(8'd250, 8'd2);  expect_run(255);
    check("final_product", 32'(bus.product), 32'd500);

    @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
